// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter: the cache-line type,
// arbiter state and port encodings, and small conversion helpers.
package mem_arbiter_pkg;

  localparam int unsigned ADR_W  = 12;
  localparam int unsigned SEL_W  = 16;
  localparam int unsigned LINE_W = 128;

  typedef logic [LINE_W-1:0] lc3b_line;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'b00,
    ARB_IFETCH = 2'b01,
    ARB_DATA   = 2'b10
  } arb_state_t;

  typedef enum logic {
    PORT_IFETCH = 1'b0,
    PORT_DATA   = 1'b1
  } arb_port_t;

  function automatic arb_port_t other_port(input arb_port_t p);
    return (p == PORT_IFETCH) ? PORT_DATA : PORT_IFETCH;
  endfunction

  function automatic arb_state_t port_state(input arb_port_t p);
    return (p == PORT_IFETCH) ? ARB_IFETCH : ARB_DATA;
  endfunction

endpackage

// File: rtl/wb_port_mux.sv
// Combinational 2:1 selector of the Wishbone master signal group onto the
// downstream port, steered by the arbiter state.
module wb_port_mux
  import mem_arbiter_pkg::*;
(
  input  arb_state_t       state,
  input  logic [ADR_W-1:0] i_adr,
  input  lc3b_line         i_dat_m,
  input  logic [SEL_W-1:0] i_sel,
  input  logic             i_we,
  input  logic             i_stb,
  input  logic             i_cyc,
  input  logic [ADR_W-1:0] d_adr,
  input  lc3b_line         d_dat_m,
  input  logic [SEL_W-1:0] d_sel,
  input  logic             d_we,
  input  logic             d_stb,
  input  logic             d_cyc,
  output logic [ADR_W-1:0] pm_adr,
  output lc3b_line         pm_dat_m,
  output logic [SEL_W-1:0] pm_sel,
  output logic             pm_we,
  output logic             pm_stb,
  output logic             pm_cyc
);

  // Route the granted master; when idle, park the address on ifetch and quiesce the rest
  always_comb begin
    pm_adr   = i_adr;
    pm_dat_m = '0;
    pm_sel   = '0;
    pm_we    = 1'b0;
    pm_stb   = 1'b0;
    pm_cyc   = 1'b0;
    case (state)
      ARB_IFETCH: begin
        pm_adr   = i_adr;
        pm_dat_m = i_dat_m;
        pm_sel   = i_sel;
        pm_we    = i_we;
        pm_stb   = i_stb;
        pm_cyc   = i_cyc;
      end
      ARB_DATA: begin
        pm_adr   = d_adr;
        pm_dat_m = d_dat_m;
        pm_sel   = d_sel;
        pm_we    = d_we;
        pm_stb   = d_stb;
        pm_cyc   = d_cyc;
      end
      ARB_IDLE: begin
        pm_adr   = i_adr;
        pm_dat_m = '0;
        pm_sel   = '0;
        pm_we    = 1'b0;
        pm_stb   = 1'b0;
        pm_cyc   = 1'b0;
      end
      default: begin
        pm_adr   = i_adr;
        pm_dat_m = '0;
        pm_sel   = '0;
        pm_we    = 1'b0;
        pm_stb   = 1'b0;
        pm_cyc   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-to-one Wishbone arbiter sharing the physical-memory port between the
// ifetch and data masters; a grant is held until the slave ACKs.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter bit DATA_PRIORITY = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ADR_W-1:0] i_adr,
  input  lc3b_line         i_dat_m,
  input  logic [SEL_W-1:0] i_sel,
  input  logic             i_we,
  input  logic             i_stb,
  input  logic             i_cyc,
  output logic             i_ack,
  output lc3b_line         i_dat_s,
  input  logic [ADR_W-1:0] d_adr,
  input  lc3b_line         d_dat_m,
  input  logic [SEL_W-1:0] d_sel,
  input  logic             d_we,
  input  logic             d_stb,
  input  logic             d_cyc,
  output logic             d_ack,
  output lc3b_line         d_dat_s,
  output logic [ADR_W-1:0] pm_adr,
  output lc3b_line         pm_dat_m,
  output logic [SEL_W-1:0] pm_sel,
  output logic             pm_we,
  output logic             pm_stb,
  output logic             pm_cyc,
  input  logic             pm_ack,
  input  lc3b_line         pm_dat_s
);

  arb_state_t state_r;
  arb_state_t next_state_s;
  arb_port_t  last_grant_r;
  arb_port_t  next_last_s;
  logic       i_req_s;
  logic       d_req_s;

  assign i_req_s = i_stb & i_cyc;
  assign d_req_s = d_stb & d_cyc;

  // Grant selection and release; a port is never re-granted on its own ACK cycle
  always_comb begin
    next_state_s = state_r;
    next_last_s  = last_grant_r;
    case (state_r)
      ARB_IDLE: begin
        if (i_req_s && d_req_s) begin
          if (DATA_PRIORITY) begin
            next_state_s = ARB_DATA;
          end else begin
            next_state_s = port_state(other_port(last_grant_r));
          end
        end else if (i_req_s) begin
          next_state_s = ARB_IFETCH;
        end else if (d_req_s) begin
          next_state_s = ARB_DATA;
        end else begin
          next_state_s = ARB_IDLE;
        end
      end
      ARB_IFETCH: begin
        if (pm_ack) begin
          next_last_s  = PORT_IFETCH;
          next_state_s = d_req_s ? ARB_DATA : ARB_IDLE;
        end else begin
          next_state_s = ARB_IFETCH;
        end
      end
      ARB_DATA: begin
        if (pm_ack) begin
          next_last_s  = PORT_DATA;
          next_state_s = i_req_s ? ARB_IFETCH : ARB_IDLE;
        end else begin
          next_state_s = ARB_DATA;
        end
      end
      default: begin
        next_state_s = ARB_IDLE;
        next_last_s  = PORT_DATA;
      end
    endcase
  end

  // State and fairness registers; reset biases the first contested grant to ifetch
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ARB_IDLE;
      last_grant_r <= PORT_DATA;
    end else begin
      state_r      <= next_state_s;
      last_grant_r <= next_last_s;
    end
  end

  assign i_ack   = pm_ack & (state_r == ARB_IFETCH) & ~rst;
  assign d_ack   = pm_ack & (state_r == ARB_DATA) & ~rst;
  assign i_dat_s = pm_dat_s;
  assign d_dat_s = pm_dat_s;

  wb_port_mux u_mux (
    .state    (state_r),
    .i_adr    (i_adr),
    .i_dat_m  (i_dat_m),
    .i_sel    (i_sel),
    .i_we     (i_we),
    .i_stb    (i_stb),
    .i_cyc    (i_cyc),
    .d_adr    (d_adr),
    .d_dat_m  (d_dat_m),
    .d_sel    (d_sel),
    .d_we     (d_we),
    .d_stb    (d_stb),
    .d_cyc    (d_cyc),
    .pm_adr   (pm_adr),
    .pm_dat_m (pm_dat_m),
    .pm_sel   (pm_sel),
    .pm_we    (pm_we),
    .pm_stb   (pm_stb),
    .pm_cyc   (pm_cyc)
  );

endmodule
